fpadd_seq: RTL and testbench
============================

Name: fpadd_seq

Overview:
- Issue/collect stage wrapped around the multi-cycle fpadd core.
- Accepts operand pairs on a valid/ready stream and drives fpadd's start/a/b for one cycle per pair.
- Waits for fpadd's done, captures sum into a small result FIFO, and presents results downstream on a valid/ready stream.
- Keeps one operation in flight and never overruns the result FIFO.

Parameters:
- DEPTH, 4, result FIFO entries; power of 2, 2..16.
- TMO_CYCLES, 320, done-wait limit in cycles; must exceed fpadd worst case (255 shift + 23 search + overhead). Used only with FPSEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_a  in  32  IEEE-754 single operand a.
- in_b  in  32  IEEE-754 single operand b.
- in_ready  out  1  pair accepted on a cycle where in_valid && in_ready.
- add_start  out  1  to fpadd start; registered single-cycle pulse.
- add_a  out  32  to fpadd a; registered, held stable from issue until capture.
- add_b  out  32  to fpadd b; registered, held stable from issue until capture.
- add_sum  in  32  from fpadd sum.
- add_done  in  1  from fpadd done.
- out_valid  out  1  result FIFO non-empty.
- out_sum  out  32  head-of-FIFO result.
- out_ready  in  1  consumer pops on out_valid && out_ready.
- busy  out  1  high in ISSUE or WAIT.
- count  out  log2(DEPTH)+1  result FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-operation):
  - state := IDLE; add_start, out_valid, busy := 0; count := 0; add_a, add_b := 0; FIFO pointers := 0.
  - Any in-flight fpadd result is discarded; the next pair reissues start, which reloads the core.
- States: IDLE, ISSUE, WAIT, CAPTURE.
- in_ready = (state==IDLE) && (count < DEPTH). This is combinational, with no dependence on in_valid.
- IDLE: on accept, register in_a/in_b into add_a/add_b and go to ISSUE.
- ISSUE: add_start=1 for exactly this cycle; go to WAIT next cycle.
  - fpadd clears done on the start edge. Therefore add_done is ignored in ISSUE and only sampled in WAIT.
- WAIT: when add_done==1, go to CAPTURE.
- CAPTURE: push add_sum into the FIFO and return to IDLE.
  - A slot is guaranteed, because acceptance required count<DEPTH and only this block pushes.
  - Minimum issue-to-issue period is 4 cycles plus fpadd latency.
- FIFO:
  - Circular buffer, wrap at DEPTH; out_sum = mem[rd_ptr], available the same cycle as out_valid.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop when empty is impossible, since out_valid=0 then.
- Back-to-back input with the FIFO full: in_ready stays 0 until a pop lowers count; acceptance occurs the cycle after.
- Ordering: results leave in acceptance order; no reordering, no drops.

Optional Feature:
- Macro: FPSEQ_TIMEOUT_EN.
- With the macro defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TMO_CYCLES with add_done still 0, push 32'h7FC00000 (quiet NaN) instead of add_sum, pulse extra output port tmo (1 bit, registered, one cycle), and return to IDLE through CAPTURE.
  - tmo resets to 0.
- Without the macro: no counter, no tmo port; WAIT waits indefinitely.

Test Plan:
- Single add, reset then 3.0+1.0 (in_a=32'h40400000, in_b=32'h3F800000), out_ready=1:
  - one add_start pulse with add_a/add_b equal to those values;
  - after done, out_valid=1 with out_sum=32'h40800000 for one cycle; count returns to 0.
- Stale done: the previous op leaves add_done=1, then a new pair is issued:
  - the old sum is not captured in the ISSUE cycle;
  - exactly one push per accepted pair.
- FIFO full: out_ready=0, push 5 pairs with DEPTH=4:
  - count reaches 4 and in_ready=0;
  - 5th pair not accepted until one pop;
  - pops return results in order (1+1=32'h40000000, 2+2=32'h40800000, ...).
- Simultaneous push/pop: count=2 with out_ready=1 in the CAPTURE cycle → count stays 2 and the head advances.
- Reset mid-WAIT: assert reset during WAIT → next cycle state IDLE, count=0, out_valid=0; a fresh pair completes correctly.
- FPSEQ_TIMEOUT_EN with TMO_CYCLES=8: hold a stub add_done=0 → tmo pulse after 8 WAIT cycles, out_sum=32'h7FC00000.

Source files
------------

// File: rtl/fpadd_seq.sv
// Issue/collect wrapper around the multi-cycle fpadd core: one add in flight, results queued in a small FIFO.
// Optional build macro FPSEQ_TIMEOUT_EN adds a done-wait timeout with a tmo pulse and quiet-NaN result.
//
// state   | meaning
// IDLE    | waiting for an operand pair (needs a free FIFO slot)
// ISSUE   | add_start pulse to fpadd; stale add_done ignored
// WAIT    | waiting for add_done
// CAPTURE | push the sum (or NaN on timeout) into the FIFO
module fpadd_seq #(
  parameter int DEPTH      = 4,
  parameter int TMO_CYCLES = 320
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic                     in_ready,
  output logic                     add_start,
  output logic [31:0]              add_a,
  output logic [31:0]              add_b,
  input  logic [31:0]              add_sum,
  input  logic                     add_done,
  output logic                     out_valid,
  output logic [31:0]              out_sum,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
`ifdef FPSEQ_TIMEOUT_EN
  ,
  output logic                     tmo
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t        state, state_next;
  logic          accept, push, pop, tmo_hit;
  logic [31:0]   push_data;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign in_ready  = (state == IDLE) && (count < CW'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = (state == CAPTURE);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_sum   = mem[rd_ptr];
  assign busy      = (state == ISSUE) || (state == WAIT);

`ifdef FPSEQ_TIMEOUT_EN
  localparam int WCW = $clog2(TMO_CYCLES + 1);
  logic [WCW-1:0] wait_cnt;

  assign tmo_hit   = (state == WAIT) && !add_done && (wait_cnt == WCW'(TMO_CYCLES - 1));
  // tmo is high exactly in the CAPTURE cycle that follows a timeout
  assign push_data = tmo ? 32'h7FC0_0000 : add_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      tmo      <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      tmo      <= tmo_hit;
    end
  end
`else
  // The timeout limit only matters in the timeout build.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TMO_CYCLES;
  assign tmo_hit        = 1'b0;
  assign push_data      = add_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (add_done || tmo_hit) state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      add_start <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
    end else begin
      add_start <= accept;
      if (accept) begin
        add_a <= in_a;
        add_b <= in_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_fpadd_seq.sv
// Directed bench for fpadd_seq with a behavioural fpadd stand-in returning hand-tabulated sums.
// Build with FPSEQ_TIMEOUT_EN to also exercise the timeout path (TMO_CYCLES=8).
module tb_fpadd_seq;

  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] F4  = 32'h4080_0000;
  localparam logic [31:0] F5  = 32'h40A0_0000;
  localparam logic [31:0] F6  = 32'h40C0_0000;
  localparam logic [31:0] F8  = 32'h4100_0000;
  localparam logic [31:0] F10 = 32'h4120_0000;

  logic        clk = 0, reset = 1;
  logic        in_valid = 0, out_ready = 0;
  logic [31:0] in_a = 0, in_b = 0;
  logic        in_ready, add_start, add_done, out_valid, busy;
  logic [31:0] add_a, add_b, add_sum, out_sum;
  logic [2:0]  count;
  logic        tmo;

  int n_chk = 0, n_pass = 0;
  int n_start = 0;
  logic [31:0] st_a, st_b;

  // fpadd stand-in: done clears on the start edge, rises LAT edges later and stays high
  int          lat = 5;
  bit          stub_hang = 0;
  int          stub_cnt = 0;
  logic        stub_done = 0;
  logic [31:0] stub_sum = 0, sa = 0, sb = 0;

  assign add_done = stub_done;
  assign add_sum  = stub_sum;

  function automatic logic [31:0] lookup(logic [31:0] a, logic [31:0] b);
    case ({a, b})
      {F1, F1}: return F2;
      {F2, F2}: return F4;
      {F3, F3}: return F6;
      {F4, F4}: return F8;
      {F5, F5}: return F10;
      {F3, F1}: return F4;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (add_start) begin
      stub_done <= 1'b0;
      stub_cnt  <= stub_hang ? 0 : lat;
      sa        <= add_a;
      sb        <= add_b;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_done <= 1'b1;
        stub_sum  <= lookup(sa, sb);
      end
    end
  end

  always @(negedge clk) begin
    if (add_start) begin
      n_start++;
      st_a = add_a;
      st_b = add_b;
    end
  end

  always #5 clk = ~clk;

`ifdef FPSEQ_TIMEOUT_EN
  fpadd_seq #(.DEPTH(4), .TMO_CYCLES(8)) dut (
`else
  fpadd_seq #(.DEPTH(4), .TMO_CYCLES(320)) dut (
`endif
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_done(add_done),
    .out_valid(out_valid), .out_sum(out_sum), .out_ready(out_ready),
    .busy(busy), .count(count)
`ifdef FPSEQ_TIMEOUT_EN
    , .tmo(tmo)
`endif
  );

`ifndef FPSEQ_TIMEOUT_EN
  assign tmo = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge of the ISSUE cycle.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit rdy, ok;
    ok = 0;
    in_valid = 1; in_a = a; in_b = b;
    for (int i = 0; i < 400; i++) begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin ok = 1; break; end
      @(negedge clk);
    end
    check("send_accepted", {31'b0, ok}, 32'd1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_count(input int exp);
    for (int i = 0; i < 200; i++) begin
      if (count == exp[2:0]) break;
      @(negedge clk);
    end
    check("wait_count", {29'b0, count}, exp);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check(tag, out_sum, exp);
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    int n, starts0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_count",     {29'b0, count},     32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_add_start", {31'b0, add_start}, 32'd0);
    check("rst_add_a",     add_a,              32'd0);
    check("rst_add_b",     add_b,              32'd0);

    // single add 3.0 + 1.0 with the consumer always ready
    out_ready = 1;
    starts0 = n_start;
    send(F3, F1);
    check("single_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 100; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    check("single_valid", {31'b0, out_valid}, 32'd1);
    check("single_sum", out_sum, F4);
    @(negedge clk);
    check("single_valid_gone", {31'b0, out_valid}, 32'd0);
    check("single_count", {29'b0, count}, 32'd0);
    check("single_starts", n_start - starts0, 32'd1);
    check("single_add_a", st_a, F3);
    check("single_add_b", st_b, F1);
    out_ready = 0;

    // stale done from the previous op must not be captured in ISSUE
    check("stale_pre_done", {31'b0, add_done}, 32'd1);
    send(F1, F1);
    check("stale_done_in_issue", {31'b0, add_done}, 32'd1);
    check("stale_no_push", {29'b0, count}, 32'd0);
    wait_count(1);
    check("stale_sum", out_sum, F2);
    repeat (10) @(negedge clk);
    check("stale_one_push", {29'b0, count}, 32'd1);
    pop_chk("stale_pop", F2);

    // fill the FIFO; fifth pair blocked until a pop
    send(F1, F1);
    send(F2, F2);
    send(F3, F3);
    send(F4, F4);
    wait_count(4);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1; in_a = F5; in_b = F5;
    repeat (6) @(negedge clk);
    check("full_hold_count", {29'b0, count}, 32'd4);
    check("full_hold_idle", {31'b0, busy}, 32'd0);
    pop_chk("full_pop0", F2);
    check("full_ready_after_pop", {31'b0, in_ready}, 32'd1);
    send(F5, F5);
    wait_count(4);
    pop_chk("full_pop1", F4);
    pop_chk("full_pop2", F6);
    pop_chk("full_pop3", F8);
    pop_chk("full_pop4", F10);
    check("full_empty", {29'b0, count}, 32'd0);

    // push and pop in the same cycle
    send(F1, F1);
    send(F2, F2);
    wait_count(2);
    send(F3, F3);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("pp_capture", {31'b0, busy}, 32'd0);
    check("pp_count_pre", {29'b0, count}, 32'd2);
    check("pp_head_pre", out_sum, F2);
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    check("pp_count", {29'b0, count}, 32'd2);
    check("pp_head", out_sum, F4);
    pop_chk("pp_pop1", F4);
    pop_chk("pp_pop2", F6);

    // reset while waiting on fpadd
    send(F1, F1);
    @(negedge clk);
    check("rw_in_wait", {31'b0, busy}, 32'd1);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check("rw_busy", {31'b0, busy}, 32'd0);
    check("rw_count", {29'b0, count}, 32'd0);
    check("rw_out_valid", {31'b0, out_valid}, 32'd0);
    check("rw_add_a", add_a, 32'd0);
    reset = 0;
    repeat (10) @(negedge clk);
    check("rw_discard", {29'b0, count}, 32'd0);
    check("rw_in_ready", {31'b0, in_ready}, 32'd1);
    send(F3, F1);
    wait_count(1);
    check("rw_fresh_sum", out_sum, F4);
    pop_chk("rw_pop", F4);

`ifdef FPSEQ_TIMEOUT_EN
    // fpadd never answers: NaN after 8 WAIT cycles
    stub_hang = 1;
    send(F1, F1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (tmo) break;
      @(negedge clk);
      n++;
    end
    check("tmo_pulse", {31'b0, tmo}, 32'd1);
    check("tmo_cycles", n, 32'd9);
    @(negedge clk);
    check("tmo_one_cycle", {31'b0, tmo}, 32'd0);
    check("tmo_count", {29'b0, count}, 32'd1);
    check("tmo_nan", out_sum, 32'h7FC0_0000);
    stub_hang = 0;
    pop_chk("tmo_pop", 32'h7FC0_0000);
`else
    n = 0;
    check("no_tmo", {31'b0, tmo}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
